// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-ported unified memory shared by instruction fetch and
// data access. Data wins by default; a streak limit keeps fetch from starving.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAX_DM_STREAK = 4,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              err_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned STK_W = $clog2(MAX_DM_STREAK + 1);

  typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_DM} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STK_W-1:0]  streak_q, streak_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d;
  logic              done_c;
  logic              abort_c;

  // Next-state, grant latching, completion and timeout handling
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    streak_d    = streak_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    done_c      = 1'b0;
    abort_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (dm_req_i && (!if_req_i || (streak_q < STK_W'(MAX_DM_STREAK)))) begin
            state_d     = GRANT_DM;
            mem_req_d   = 1'b1;
            mem_we_d    = dm_we_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
            if (!if_req_i) begin
              streak_d = '0;
            end else if (streak_q < STK_W'(MAX_DM_STREAK)) begin
              streak_d = streak_q + STK_W'(1);
            end
          end else if (if_req_i) begin
            state_d     = GRANT_IF;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
            streak_d    = '0;
          end
        end
      end
      GRANT_IF, GRANT_DM: begin
        if (mem_ack_i) begin
          done_c = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          done_c  = 1'b1;
          abort_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Completion or abort: release memory and return data to the winner
    if (done_c) begin
      state_d   = IDLE;
      mem_req_d = 1'b0;
      err_d     = err_q | abort_c;
      if (state_q == GRANT_IF) begin
        if_ack_d   = 1'b1;
        if_rdata_d = abort_c ? '0 : mem_rdata_i;
      end else begin
        dm_ack_d = 1'b1;
        if (abort_c) begin
          dm_rdata_d = '0;
        end else if (!mem_we_q) begin
          dm_rdata_d = mem_rdata_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      streak_q    <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;

  // Pipeline stall: a request is outstanding until its ack pulse is visible
  assign stall_o = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: a latency-programmable memory
// responder, a grant log and an ack scoreboard checked at the falling edge.
module tb_mem_port_arbiter;

  logic        clk, rst, start;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_ack_o, dm_ack_o, mem_req_o, mem_we_o, stall_o, err_o;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  mem_port_arbiter dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o), .err_o(err_o)
  );

  typedef struct { logic is_dm; logic [31:0] rdata; } exp_t;
  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; int cyc; } grant_t;

  exp_t   sb[$];
  grant_t glog[$];
  int     n_chk = 0, n_pass = 0;
  int     cyc = 0, lat = 2, stable_err = 0, pulse_err = 0;
  logic [31:0] model_dm = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h10) return 32'h00A00093;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input logic is_dm, input logic [31:0] rdata);
    exp_t e;
    e.is_dm = is_dm;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic check_ack(input logic is_dm, input logic [31:0] rdata);
    exp_t e;
    chk("ack_expected", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("ack_port", 32'(is_dm), 32'(e.is_dm));
      chk(is_dm ? "dm_rdata" : "if_rdata", rdata, e.rdata);
    end
  endtask

  task automatic wait_ack(input logic dm, input int budget, input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      seen = dm ? dm_ack_o : if_ack_o;
    end
    chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_grant(input int budget, input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      seen = mem_req_o;
    end
    chk({tag, "_grant_seen"}, 32'(seen), 32'd1);
  endtask

  // Memory responder: acks lat cycles after mem_req_o rises; lat<0 never acks
  initial begin
    int wcnt = 0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'hBAD0BAD0;
    forever begin
      @(negedge clk);
      if (rst || !mem_req_o) begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'hBAD0BAD0;
        wcnt        = 0;
      end else if (!mem_ack_i) begin
        if (lat >= 0 && wcnt == lat) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = mem_data(mem_addr_o);
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Monitor: log grants, check grant stability, one-cycle acks and ack payloads
  initial begin
    logic prev_req = 1'b0, prev_if = 1'b0, prev_dm = 1'b0;
    grant_t g;
    g = '{32'h0, 1'b0, 32'h0, 0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_req_o && !prev_req) begin
          g = '{mem_addr_o, mem_we_o, mem_wdata_o, cyc};
          glog.push_back(g);
        end else if (mem_req_o &&
                     (mem_addr_o !== g.addr || mem_we_o !== g.we || mem_wdata_o !== g.wdata)) begin
          stable_err++;
        end
        if ((if_ack_o && prev_if) || (dm_ack_o && prev_dm)) pulse_err++;
        if (if_ack_o) check_ack(1'b0, if_rdata_o);
        if (dm_ack_o) check_ack(1'b1, dm_rdata_o);
      end
      prev_req = mem_req_o;
      prev_if  = if_ack_o;
      prev_dm  = dm_ack_o;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gcyc;
    logic [31:0] star_exp [6];
    logic idle_ok;
    rst = 1'b1; start = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_if_ack", 32'(if_ack_o), 32'd0);
    chk("rst_dm_ack", 32'(dm_ack_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_if_rdata", if_rdata_o, 32'd0);
    chk("rst_dm_rdata", dm_rdata_o, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    rst = 1'b0;

    // Single fetch, memory latency 2
    @(posedge clk); #1;
    start = 1'b1; if_req = 1'b1; if_addr = 32'h10;
    push(1'b0, 32'h00A00093);
    #1 chk("fetch_stall_pending", 32'(stall_o), 32'd1);
    wait_grant(5, "fetch");
    gcyc = cyc;
    chk("fetch_mem_addr", mem_addr_o, 32'h10);
    chk("fetch_mem_we", 32'(mem_we_o), 32'd0);
    wait_ack(1'b0, 10, "fetch");
    chk("fetch_ack_latency", 32'(cyc - gcyc), 32'd3);
    chk("fetch_stall_ack", 32'(stall_o), 32'd0);
    if_req = 1'b0;
    @(posedge clk); #1;
    chk("fetch_ack_single", 32'(if_ack_o), 32'd0);
    chk("fetch_rdata_held", if_rdata_o, 32'h00A00093);
    chk("fetch_mem_req_low", 32'(mem_req_o), 32'd0);

    // Simultaneous requests: data first, then fetch
    glog.delete();
    if_req = 1'b1; if_addr = 32'h20;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    push(1'b1, mem_data(32'h40)); model_dm = mem_data(32'h40);
    push(1'b0, mem_data(32'h20));
    wait_ack(1'b1, 10, "simul_dm");
    dm_req = 1'b0;
    wait_ack(1'b0, 10, "simul_if");
    if_req = 1'b0;
    chk("simul_grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      chk("simul_first_addr", glog[0].addr, 32'h40);
      chk("simul_second_addr", glog[1].addr, 32'h20);
      chk("simul_gap", 32'(glog[1].cyc - glog[0].cyc), 32'd4);
    end

    // Starvation guard: 4 data grants, 1 fetch, then data again
    @(posedge clk); #1;
    glog.delete();
    lat = 1;
    for (int i = 0; i < 6; i++) begin
      star_exp[i] = (i == 4) ? 32'h200 : 32'h100;
      push(i != 4, mem_data(star_exp[i]));
    end
    model_dm = mem_data(32'h100);
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_addr = 32'h100;
    for (int i = 0; i < 80 && glog.size() < 6; i++) begin
      @(posedge clk); #1;
    end
    if_req = 1'b0; dm_req = 1'b0;
    chk("starve_grants", 32'(glog.size()), 32'd6);
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("starve_sb_drained", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 6; i++)
      if (i < glog.size()) chk($sformatf("starve_addr%0d", i), glog[i].addr, star_exp[i]);

    // Store: write data visible for the whole grant, load data untouched
    @(posedge clk); #1;
    glog.delete();
    lat = 2;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hDEADBEEF;
    push(1'b1, model_dm);
    wait_grant(5, "store");
    chk("store_mem_we", 32'(mem_we_o), 32'd1);
    chk("store_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
    wait_ack(1'b1, 10, "store");
    dm_req = 1'b0; dm_we = 1'b0;
    chk("store_rdata_kept", dm_rdata_o, mem_data(32'h100));

    // Timeout: memory never answers
    @(posedge clk); #1;
    glog.delete();
    lat = -1;
    if_req = 1'b1; if_addr = 32'h300;
    push(1'b0, 32'h0);
    wait_ack(1'b0, 100, "timeout");
    if_req = 1'b0;
    chk("timeout_err", 32'(err_o), 32'd1);
    chk("timeout_grants", 32'(glog.size()), 32'd1);
    if (glog.size() == 1) chk("timeout_cycles", 32'(cyc - glog[0].cyc), 32'd64);
    repeat (3) @(posedge clk);
    #1;
    chk("timeout_err_sticky", 32'(err_o), 32'd1);
    chk("timeout_idle", 32'(mem_req_o), 32'd0);
    lat = 2;

    // Reset one cycle into a grant, then regrant after release
    dm_req = 1'b1; dm_addr = 32'h44;
    wait_grant(5, "rst_mid");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mid_dm_ack", 32'(dm_ack_o), 32'd0);
    chk("rst_mid_err", 32'(err_o), 32'd0);
    chk("rst_mid_dm_rdata", dm_rdata_o, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push(1'b1, mem_data(32'h44)); model_dm = mem_data(32'h44);
    wait_ack(1'b1, 10, "rst_regrant");
    dm_req = 1'b0;

    // start_i falling mid-grant: access completes, then the arbiter idles
    @(posedge clk); #1;
    dm_req = 1'b1; dm_addr = 32'h48;
    push(1'b1, mem_data(32'h48)); model_dm = mem_data(32'h48);
    wait_grant(5, "start_drop");
    start = 1'b0; if_req = 1'b1; if_addr = 32'h24;
    wait_ack(1'b1, 10, "start_drop");
    dm_req = 1'b0;
    idle_ok = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (mem_req_o) idle_ok = 1'b0;
    end
    chk("start_low_idle", 32'(idle_ok), 32'd1);
    chk("start_low_stall", 32'(stall_o), 32'd1);
    push(1'b0, mem_data(32'h24));
    start = 1'b1;
    wait_ack(1'b0, 10, "start_resume");
    if_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    chk("final_stall", 32'(stall_o), 32'd0);
    chk("grant_stable", 32'(stable_err), 32'd0);
    chk("ack_one_cycle", 32'(pulse_err), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single-ported unified memory shared by instruction fetch (IF stage) and data access (MEM stage) of the 5-stage pipeline.
- Grants one requester at a time, holds the memory handshake until the memory acknowledges, and returns read data to the winner.
- Produces the pipeline stall that the hazard unit ORs into PCWrite/IF_ID stall.
- Data requests win by default, and a streak limit prevents fetch starvation.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DM_STREAK, 4, max consecutive DM grants while IF is waiting before IF is forced
- TIMEOUT, 64, cycles to wait for mem_ack_i before aborting

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  arbiter grants only while high; an in-flight access always completes
- if_req_i  in  1  fetch request, held until if_ack_o
- if_addr_i  in  ADDR_W  fetch address
- if_ack_o  out  1  one-cycle completion pulse to fetch
- if_rdata_o  out  DATA_W  fetched instruction, valid with if_ack_o and held after
- dm_req_i  in  1  data request, held until dm_ack_o
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_ack_o  out  1  one-cycle completion pulse to data
- dm_rdata_o  out  DATA_W  load data, valid with dm_ack_o and held after
- mem_req_o  out  1  memory request, registered
- mem_we_o  out  1  memory write enable, registered
- mem_addr_o  out  ADDR_W  memory address, registered
- mem_wdata_o  out  DATA_W  memory write data, registered
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
- mem_ack_i  in  1  memory completion, sampled only while mem_req_o=1
- stall_o  out  1  pipeline stall, combinational
- err_o  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; all ack, mem_* and err_o outputs = 0; rdata outputs = 0.
  - streak=0; timeout counter=0.
- States: IDLE, GRANT_IF, GRANT_DM.
- IDLE, with start_i=1:
  - Go to GRANT_DM if dm_req_i and (!if_req_i or streak<MAX_DM_STREAK).
  - Otherwise go to GRANT_IF if if_req_i.
  - Otherwise stay in IDLE.
- IDLE, with start_i=0: stay in IDLE.
- On entering a GRANT state:
  - Latch the winner's addr/we/wdata into mem_* and set mem_req_o=1 in the same edge.
  - IF grants force mem_we_o=0.
  - mem_* outputs are stable for the whole grant.
- GRANT_x and mem_ack_i=1:
  - Next edge: x_ack_o=1 for one cycle; x_rdata_o<=mem_rdata_i (loads and fetches only; stores leave dm_rdata_o unchanged).
  - mem_req_o<=0; go to IDLE.
  - Minimum turnaround: request sampled at edge N, mem_req_o high from N, ack at earliest cycle N, x_ack_o high cycle N+1, next grant no earlier than edge N+2.
- Timeout:
  - Counter increments each cycle in a GRANT state and clears on every state change.
  - When it reaches TIMEOUT-1 with no mem_ack_i: abort to IDLE, pulse x_ack_o, set x_rdata_o=0, set err_o=1.
  - err_o clears only on reset.
- Streak:
  - On a GRANT_DM entry with if_req_i=1: streak=min(streak+1, MAX_DM_STREAK).
  - On a GRANT_DM entry with if_req_i=0: streak=0.
  - On any GRANT_IF entry: streak=0.
- stall_o = (if_req_i & !if_ack_o) | (dm_req_i & !dm_ack_o).
- Boundaries:
  - A requester dropping its req mid-grant does not cancel the grant; the access completes and the ack is still pulsed.
  - A req asserted in the same cycle as its own ack pulse is treated as a new request.
  - start_i falling mid-grant lets the access finish; the FSM then idles.
  - mem_ack_i seen while in IDLE is ignored.
  - rst_i mid-grant returns to IDLE immediately; no ack is issued.

Test Plan:
- Single fetch: if_req_i=1, addr=0x10; memory acks 2 cycles after mem_req_o with 0x00A00093 -> mem_addr_o=0x10, mem_we_o=0; if_ack_o is one pulse carrying if_rdata_o=0x00A00093; stall_o drops in the ack cycle.
- Simultaneous requests: if_req_i and dm_req_i rise together, dm load addr=0x40 -> DM served first, then IF; mem_addr_o sequence 0x40, then fetch addr; one IDLE cycle between the grants.
- Starvation: dm_req_i held high continuously (re-asserted each ack) with if_req_i=1, MAX_DM_STREAK=4 -> exactly 4 DM grants, then 1 IF grant, then DM resumes.
- Store: dm_we_i=1, addr=0x80, wdata=0xDEADBEEF -> mem_we_o=1 and mem_wdata_o=0xDEADBEEF for the whole grant; dm_ack_o pulses; dm_rdata_o unchanged.
- Timeout: memory never acks, TIMEOUT=64 -> after 64 cycles in GRANT, the ack pulse has rdata=0, err_o=1 and stays high, and the FSM returns to IDLE.
- Reset mid-grant: assert rst_i 1 cycle after mem_req_o rises -> mem_req_o=0 asynchronously, no ack, state=IDLE; after release, a pending request is re-granted normally.
